// File: rtl/wb_queue_pkg.sv
// Shared types and sizing for the writeback queue feeding the 4x8 register file.
package wb_pkg;
  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int NREG  = 1 << AW;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;

  // DEPTH is a power of two, so plain binary addition wraps modulo DEPTH.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [PW-1:0] n);
    return p + n;
  endfunction
endpackage

// File: rtl/wb_queue_if.sv
// Producer pushes, register-file write port and read-port snoop of the writeback queue.
interface wb_queue_if;
  import wb_pkg::*;

  logic            AluValid;
  logic [AW-1:0]   AluWaddr;
  logic [DW-1:0]   AluData;
  logic            LdValid;
  logic [AW-1:0]   LdWaddr;
  logic [DW-1:0]   LdData;
  logic            Stall;
  logic            Overflow;
  logic            WriteEn;
  logic [AW-1:0]   Waddr;
  logic [DW-1:0]   DataIn;
  logic [AW-1:0]   RaddrA;
  logic [AW-1:0]   RaddrB;
  logic            FwdHitA;
  logic            FwdHitB;
  logic [DW-1:0]   FwdDataA;
  logic [DW-1:0]   FwdDataB;
  logic [NREG-1:0] Busy;

  modport master (
    output AluValid, AluWaddr, AluData, LdValid, LdWaddr, LdData, RaddrA, RaddrB,
    input  Stall, Overflow, WriteEn, Waddr, DataIn, FwdHitA, FwdHitB, FwdDataA, FwdDataB, Busy
  );

  modport slave (
    input  AluValid, AluWaddr, AluData, LdValid, LdWaddr, LdData, RaddrA, RaddrB,
    output Stall, Overflow, WriteEn, Waddr, DataIn, FwdHitA, FwdHitB, FwdDataA, FwdDataB, Busy
  );
endinterface

// File: rtl/wb_fwd_match.sv
// One read port's forwarding lookup: youngest valid entry matching raddr wins.
module wb_fwd_match
  import wb_pkg::*;
(
  input  wb_entry_t        entries [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  logic [PW-1:0]    head,
  input  logic [AW-1:0]    raddr,
  output logic             hit,
  output logic [DW-1:0]    data
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = ptr_add(head, PW'(k));
      if (valid[idx] && (entries[idx].addr == raddr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Writeback queue: in-order buffering of load/ALU results with one retirement per cycle.
module wb_queue
  import wb_pkg::*;
(
  input logic        Clk,
  input logic        Reset,
  wb_queue_if.slave  bus
);

  wb_entry_t        entries_q [DEPTH];
  wb_entry_t        entries_d [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;

  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    age;
  logic             pop;
  logic [CW-1:0]    occ;
  logic [CW-1:0]    free;
  logic             ld_acc;
  logic             alu_acc;
  logic             drop;
  logic [NREG-1:0]  busy;
  wb_entry_t        head_entry;

  always_comb begin
    valid = '0;
    age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age      = PW'(i) - head_q;
      valid[i] = ({1'b0, age} < count_q);
    end
  end

  // Capacity is judged after this cycle's pop; load is older so it claims a slot first.
  assign pop     = (count_q != '0);
  assign occ     = count_q - CW'(pop);
  assign free    = CW'(DEPTH) - occ;
  assign ld_acc  = bus.LdValid && (free >= CW'(1));
  assign alu_acc = bus.AluValid && (free >= (CW'(1) + CW'(ld_acc)));
  assign drop    = (bus.LdValid && !ld_acc) || (bus.AluValid && !alu_acc);

  always_comb begin
    entries_d  = entries_q;
    head_d     = ptr_add(head_q, PW'(pop));
    tail_d     = ptr_add(tail_q, PW'(ld_acc) + PW'(alu_acc));
    count_d    = occ + CW'(ld_acc) + CW'(alu_acc);
    overflow_d = overflow_q | drop;
    if (ld_acc) begin
      entries_d[tail_q] = '{addr: bus.LdWaddr, data: bus.LdData};
    end
    if (alu_acc) begin
      entries_d[ptr_add(tail_q, PW'(ld_acc))] = '{addr: bus.AluWaddr, data: bus.AluData};
    end
    if (Reset) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    entries_q  <= entries_d;
    head_q     <= head_d;
    tail_q     <= tail_d;
    count_q    <= count_d;
    overflow_q <= overflow_d;
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) begin
        busy[entries_q[i].addr] = 1'b1;
      end
    end
  end

  assign head_entry   = entries_q[head_q];
  assign bus.WriteEn  = pop && !Reset;
  assign bus.Waddr    = pop ? head_entry.addr : '0;
  assign bus.DataIn   = pop ? head_entry.data : '0;
  assign bus.Stall    = (count_q >= CW'(DEPTH - 1));
  assign bus.Overflow = overflow_q;
  assign bus.Busy     = busy;

  wb_fwd_match u_fwd_a (
    .entries (entries_q),
    .valid   (valid),
    .head    (head_q),
    .raddr   (bus.RaddrA),
    .hit     (bus.FwdHitA),
    .data    (bus.FwdDataA)
  );

  wb_fwd_match u_fwd_b (
    .entries (entries_q),
    .valid   (valid),
    .head    (head_q),
    .raddr   (bus.RaddrB),
    .hit     (bus.FwdHitB),
    .data    (bus.FwdDataB)
  );

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: hand-computed retire order, forwarding, stall and overflow.
module tb_wb_queue;
  import wb_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  wb_queue_if bus ();

  wb_queue dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                      input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad);
    bus.LdValid  = lv;
    bus.LdWaddr  = la;
    bus.LdData   = ld;
    bus.AluValid = av;
    bus.AluWaddr = aa;
    bus.AluData  = ad;
  endtask

  task automatic idle();
    push(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] drain_exp [3];
    drain_exp[0] = 8'h46;
    drain_exp[1] = 8'h4F;
    drain_exp[2] = 8'h47;

    Reset = 1'b1;
    idle();
    bus.RaddrA = '0;
    bus.RaddrB = '0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    #1;
    chk("rst_we",    32'(bus.WriteEn),  0);
    chk("rst_waddr", 32'(bus.Waddr),    0);
    chk("rst_data",  32'(bus.DataIn),   0);
    chk("rst_stall", 32'(bus.Stall),    0);
    chk("rst_ovf",   32'(bus.Overflow), 0);
    chk("rst_busy",  32'(bus.Busy),     0);
    chk("rst_hita",  32'(bus.FwdHitA),  0);
    chk("rst_dataa", 32'(bus.FwdDataA), 0);

    // single ALU push
    push(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'h5A);
    cyc();
    idle();
    bus.RaddrA = 2'd2;
    #1;
    chk("t1_we",    32'(bus.WriteEn),  1);
    chk("t1_waddr", 32'(bus.Waddr),    2);
    chk("t1_data",  32'(bus.DataIn),   32'h5A);
    chk("t1_hita",  32'(bus.FwdHitA),  1);
    chk("t1_fwda",  32'(bus.FwdDataA), 32'h5A);
    chk("t1_busy",  32'(bus.Busy),     32'h4);
    cyc();
    #1;
    chk("t1_we_off",  32'(bus.WriteEn), 0);
    chk("t1_busy_off", 32'(bus.Busy),   0);
    chk("t1_hita_off", 32'(bus.FwdHitA), 0);

    // same-cycle load + ALU to r1
    push(1'b1, 2'd1, 8'h11, 1'b1, 2'd1, 8'h22);
    cyc();
    idle();
    bus.RaddrA = 2'd1;
    #1;
    chk("t2_waddr0", 32'(bus.Waddr),    1);
    chk("t2_data0",  32'(bus.DataIn),   32'h11);
    chk("t2_hita0",  32'(bus.FwdHitA),  1);
    chk("t2_fwda0",  32'(bus.FwdDataA), 32'h22);
    chk("t2_busy0",  32'(bus.Busy),     32'h2);
    cyc();
    #1;
    chk("t2_we1",   32'(bus.WriteEn),  1);
    chk("t2_data1", 32'(bus.DataIn),   32'h22);
    chk("t2_fwda1", 32'(bus.FwdDataA), 32'h22);
    cyc();
    #1;
    chk("t2_we2", 32'(bus.WriteEn), 0);

    // dual pushes obeying Stall
    push(1'b1, 2'd0, 8'h31, 1'b1, 2'd1, 8'h32);
    cyc();
    push(1'b1, 2'd2, 8'h33, 1'b1, 2'd3, 8'h34);
    #1;
    chk("t3_stall_c2", 32'(bus.Stall),  0);
    chk("t3_data31",   32'(bus.DataIn), 32'h31);
    cyc();
    idle();
    #1;
    chk("t3_stall_c3", 32'(bus.Stall),  1);
    chk("t3_data32",   32'(bus.DataIn), 32'h32);
    chk("t3_busy",     32'(bus.Busy),   32'hE);
    cyc();
    #1;
    chk("t3_data33",  32'(bus.DataIn), 32'h33);
    chk("t3_stall_c2b", 32'(bus.Stall), 0);
    cyc();
    #1;
    chk("t3_data34", 32'(bus.DataIn), 32'h34);
    cyc();
    #1;
    chk("t3_we_off", 32'(bus.WriteEn),  0);
    chk("t3_ovf",    32'(bus.Overflow), 0);

    // fill to 4, full+pop+1 push, then dual push ignoring Stall
    push(1'b1, 2'd0, 8'h41, 1'b1, 2'd1, 8'h42);
    cyc();
    push(1'b1, 2'd2, 8'h43, 1'b1, 2'd3, 8'h44);
    cyc();
    push(1'b1, 2'd0, 8'h45, 1'b1, 2'd1, 8'h46);
    #1;
    chk("t4_data42", 32'(bus.DataIn), 32'h42);
    cyc();
    push(1'b1, 2'd3, 8'h4F, 1'b0, 2'd0, 8'h00);
    #1;
    chk("t4_full_stall", 32'(bus.Stall),    1);
    chk("t4_data43",     32'(bus.DataIn),   32'h43);
    chk("t4_full_busy",  32'(bus.Busy),     32'hF);
    chk("t4_ovf_pre",    32'(bus.Overflow), 0);
    cyc();
    push(1'b1, 2'd2, 8'h47, 1'b1, 2'd0, 8'h48);
    #1;
    chk("t4_ovf_full1", 32'(bus.Overflow), 0);
    chk("t4_data44",    32'(bus.DataIn),   32'h44);
    chk("t4_stall_f1",  32'(bus.Stall),    1);
    cyc();
    idle();
    bus.RaddrA = 2'd0;
    bus.RaddrB = 2'd3;
    #1;
    chk("t4_ovf_set", 32'(bus.Overflow), 1);
    chk("t4_data45",  32'(bus.DataIn),   32'h45);
    chk("t4_fwda",    32'(bus.FwdDataA), 32'h45);
    chk("t4_hitb",    32'(bus.FwdHitB),  1);
    chk("t4_fwdb",    32'(bus.FwdDataB), 32'h4F);
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      chk("t4_drain", 32'(bus.DataIn), 32'(drain_exp[i]));
    end
    cyc();
    #1;
    chk("t4_we_off",   32'(bus.WriteEn),  0);
    chk("t4_ovf_hold", 32'(bus.Overflow), 1);

    // one push per cycle for 12 cycles: pointers wrap, order held
    for (int i = 0; i < 12; i++) begin
      push(1'b1, 2'(i % 4), 8'(8'h60 + i), 1'b0, 2'd0, 8'h00);
      cyc();
      #1;
      chk("t5_data", 32'(bus.DataIn), 32'(8'h60 + i));
      chk("t5_busy", 32'(bus.Busy),   32'(1 << (i % 4)));
    end
    idle();
    cyc();
    #1;
    chk("t5_we_off", 32'(bus.WriteEn), 0);

    // reset with 3 pending
    push(1'b1, 2'd1, 8'h71, 1'b1, 2'd2, 8'h72);
    cyc();
    push(1'b1, 2'd3, 8'h73, 1'b1, 2'd0, 8'h74);
    cyc();
    idle();
    #1;
    chk("t6_stall3", 32'(bus.Stall),  1);
    chk("t6_data72", 32'(bus.DataIn), 32'h72);
    Reset = 1'b1;
    #1;
    chk("t6_we_in_rst", 32'(bus.WriteEn), 0);
    cyc();
    Reset = 1'b0;
    bus.RaddrA = 2'd2;
    bus.RaddrB = 2'd3;
    #1;
    chk("t6_we",    32'(bus.WriteEn),  0);
    chk("t6_busy",  32'(bus.Busy),     0);
    chk("t6_hita",  32'(bus.FwdHitA),  0);
    chk("t6_hitb",  32'(bus.FwdHitB),  0);
    chk("t6_fwda",  32'(bus.FwdDataA), 0);
    chk("t6_ovf",   32'(bus.Overflow), 0);
    chk("t6_stall", 32'(bus.Stall),    0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
